// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM states, IF/ID register operations, vectors, bubble.
package cpu_pkg;

  localparam logic [15:0] NOP_INSTR      = 16'h4000;
  localparam logic [31:0] RESET_VEC_ADDR = 32'd0;
  localparam logic [31:0] INT_VEC_ADDR   = 32'd2;

  typedef enum logic [2:0] {
    BOOT_HI,
    BOOT_LO,
    RUN,
    IVEC_HI,
    IVEC_LO
  } fetch_state_t;

  typedef enum logic [1:0] {
    IFID_HOLD,
    IFID_FLUSH,
    IFID_LOAD,
    IFID_IMM
  } if_id_op_t;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: hold, flush to bubble, load instruction, or capture an immediate.
module if_id_reg
  import cpu_pkg::*;
#(
  parameter int unsigned PC_W    = 32,
  parameter int unsigned INSTR_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  if_id_op_t          op,
  input  logic [INSTR_W-1:0] fetch_word,
  input  logic [PC_W-1:0]    fetch_pc,
  output logic [INSTR_W-1:0] instruction,
  output logic [PC_W-1:0]    pc,
  output logic [INSTR_W-1:0] imm
);

  // Update the latched instruction, its address and the immediate word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instruction <= INSTR_W'(NOP_INSTR);
      pc          <= '0;
      imm         <= '0;
    end else begin
      case (op)
        IFID_FLUSH: instruction <= INSTR_W'(NOP_INSTR);
        IFID_LOAD: begin
          instruction <= fetch_word;
          pc          <= fetch_pc;
        end
        IFID_IMM: begin
          instruction <= INSTR_W'(NOP_INSTR);
          pc          <= fetch_pc;
          imm         <= fetch_word;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, vector loads, next-PC selection, interrupt latch.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter int unsigned PC_W    = 32,
  parameter int unsigned INSTR_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  input  logic               stall_fetch_from_cu,
  input  logic               hazard_stall,
  input  logic               clear_instruction,
  input  logic               pc_write_cu,
  input  logic               pc_choose_memory,
  input  logic [PC_W-1:0]    mem_pc,
  input  logic               jump_taken,
  input  logic [PC_W-1:0]    jump_target,
  input  logic               pc_choose_interrupt,
  input  logic               ext_interrupt,
  output logic [INSTR_W-1:0] instruction,
  output logic [PC_W-1:0]    if_id_pc,
  output logic [INSTR_W-1:0] if_id_imm,
  output logic               interrupt_signal,
  output logic [PC_W-1:0]    return_pc,
  output logic               fetch_ready
);

  fetch_state_t    state;
  logic [PC_W-1:0] pc;
  logic            int_pending;
  logic            ext_prev;
  logic            stall_any;
  logic            redirect;
  logic            fire;
  logic            ext_edge;
  if_id_op_t       if_id_op;

  assign stall_any = stall_fetch_from_cu | hazard_stall;
  assign redirect  = pc_choose_interrupt | pc_choose_memory | jump_taken;
  assign ext_edge  = ext_interrupt & ~ext_prev;
  assign fire      = int_pending & (state == RUN) & ~stall_any & ~clear_instruction & ~redirect;

  // Memory address: vector halves while loading, otherwise the PC.
  always_comb begin
    imem_addr = pc;
    case (state)
      BOOT_HI: imem_addr = PC_W'(RESET_VEC_ADDR);
      BOOT_LO: imem_addr = PC_W'(RESET_VEC_ADDR + 32'd1);
      IVEC_HI: imem_addr = PC_W'(INT_VEC_ADDR);
      IVEC_LO: imem_addr = PC_W'(INT_VEC_ADDR + 32'd1);
      default: imem_addr = pc;
    endcase
  end

  // IF/ID control: bubbles during vector loads and redirects, hold on stall.
  always_comb begin
    if_id_op = IFID_HOLD;
    if (state != RUN)                    if_id_op = IFID_FLUSH;
    else if (redirect)                   if_id_op = IFID_FLUSH;
    else if (stall_any || !pc_write_cu)  if_id_op = IFID_HOLD;
    else if (clear_instruction)          if_id_op = IFID_IMM;
    else                                 if_id_op = IFID_LOAD;
  end

  // Fetch FSM, PC update and interrupt latch.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= BOOT_HI;
      pc               <= '0;
      return_pc        <= '0;
      fetch_ready      <= 1'b0;
      int_pending      <= 1'b0;
      interrupt_signal <= 1'b0;
      ext_prev         <= 1'b0;
    end else begin
      ext_prev         <= ext_interrupt;
      interrupt_signal <= fire;
      int_pending      <= ext_edge | (int_pending & ~fire);
      case (state)
        BOOT_HI, IVEC_HI: begin
          pc    <= {imem_data, pc[INSTR_W-1:0]};
          state <= (state == BOOT_HI) ? BOOT_LO : IVEC_LO;
        end
        BOOT_LO, IVEC_LO: begin
          pc          <= {pc[PC_W-1:INSTR_W], imem_data};
          state       <= RUN;
          fetch_ready <= 1'b1;
        end
        RUN: begin
          if (pc_choose_interrupt) begin
            return_pc   <= pc;
            state       <= IVEC_HI;
            fetch_ready <= 1'b0;
          end else if (pc_choose_memory) begin
            pc <= mem_pc;
          end else if (jump_taken) begin
            pc <= jump_target;
          end else if (!stall_any && pc_write_cu) begin
            pc <= pc + PC_W'(1);
          end
        end
        default: begin
          state       <= BOOT_HI;
          fetch_ready <= 1'b0;
        end
      endcase
    end
  end

  if_id_reg #(
    .PC_W    (PC_W),
    .INSTR_W (INSTR_W)
  ) u_if_id (
    .clk         (clk),
    .reset       (reset),
    .op          (if_id_op),
    .fetch_word  (imem_data),
    .fetch_pc    (pc),
    .instruction (instruction),
    .pc          (if_id_pc),
    .imm         (if_id_imm)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed and randomized checks of fetch_stage against a behavioural model.
module tb_fetch_stage;

  localparam logic [15:0] NOP = 16'h4000;

  logic        clk;
  logic        reset;
  logic [31:0] imem_addr;
  logic [15:0] imem_data;
  logic        stall_fetch_from_cu, hazard_stall, clear_instruction, pc_write_cu;
  logic        pc_choose_memory, jump_taken, pc_choose_interrupt, ext_interrupt;
  logic [31:0] mem_pc, jump_target;
  logic [15:0] instruction, if_id_imm;
  logic [31:0] if_id_pc, return_pc;
  logic        interrupt_signal, fetch_ready;

  logic [15:0] mem [0:1023];
  int total = 0;
  int bad   = 0;

  // model state: vec_left = vector halves still to load (2, 1, or 0 when running)
  int          vec_left;
  logic [31:0] vec_base, m_pc, m_ifpc, m_ret;
  logic [15:0] m_instr, m_imm;
  logic        m_pend, m_isig, m_prev;

  assign imem_data = mem[imem_addr[9:0]];

  fetch_stage dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_data(imem_data),
    .stall_fetch_from_cu(stall_fetch_from_cu), .hazard_stall(hazard_stall),
    .clear_instruction(clear_instruction), .pc_write_cu(pc_write_cu),
    .pc_choose_memory(pc_choose_memory), .mem_pc(mem_pc),
    .jump_taken(jump_taken), .jump_target(jump_target),
    .pc_choose_interrupt(pc_choose_interrupt), .ext_interrupt(ext_interrupt),
    .instruction(instruction), .if_id_pc(if_id_pc), .if_id_imm(if_id_imm),
    .interrupt_signal(interrupt_signal), .return_pc(return_pc), .fetch_ready(fetch_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_addr();
    if (vec_left == 2) return vec_base;
    if (vec_left == 1) return vec_base + 32'd1;
    return m_pc;
  endfunction

  task automatic model_reset();
    vec_left = 2; vec_base = 32'd0; m_pc = '0; m_ifpc = '0; m_ret = '0;
    m_instr = NOP; m_imm = '0; m_pend = 0; m_isig = 0; m_prev = 0;
  endtask

  task automatic model_step();
    logic [15:0] data;
    logic        stalled, fire_now;
    data     = mem[model_addr() % 1024];
    stalled  = stall_fetch_from_cu || hazard_stall;
    fire_now = m_pend && vec_left == 0 && !stalled && !clear_instruction &&
               !(pc_choose_interrupt || pc_choose_memory || jump_taken);
    m_pend   = (ext_interrupt && !m_prev) || (m_pend && !fire_now);
    m_isig   = fire_now;
    m_prev   = ext_interrupt;
    if (vec_left == 2) begin
      m_pc = {data, m_pc[15:0]}; m_instr = NOP; vec_left = 1;
    end else if (vec_left == 1) begin
      m_pc = {m_pc[31:16], data}; m_instr = NOP; vec_left = 0;
    end else if (pc_choose_interrupt) begin
      m_ret = m_pc; m_instr = NOP; vec_left = 2; vec_base = 32'd2;
    end else if (pc_choose_memory) begin
      m_pc = mem_pc; m_instr = NOP;
    end else if (jump_taken) begin
      m_pc = jump_target; m_instr = NOP;
    end else if (stalled || !pc_write_cu) begin
      // everything holds
    end else if (clear_instruction) begin
      m_imm = data; m_instr = NOP; m_ifpc = m_pc; m_pc = m_pc + 32'd1;
    end else begin
      m_instr = data; m_ifpc = m_pc; m_pc = m_pc + 32'd1;
    end
  endtask

  // One clock: inputs already driven; check address, advance model, check outputs.
  task automatic cycle();
    #1;
    check("imem_addr", imem_addr, model_addr());
    model_step();
    @(posedge clk);
    #1;
    check("instruction", 32'(instruction), 32'(m_instr));
    check("if_id_pc", if_id_pc, m_ifpc);
    check("if_id_imm", 32'(if_id_imm), 32'(m_imm));
    check("interrupt_signal", 32'(interrupt_signal), 32'(m_isig));
    check("return_pc", return_pc, m_ret);
    check("fetch_ready", 32'(fetch_ready), 32'(vec_left == 0));
  endtask

  task automatic idle();
    stall_fetch_from_cu = 0; hazard_stall = 0; clear_instruction = 0; pc_write_cu = 1;
    pc_choose_memory = 0; jump_taken = 0; pc_choose_interrupt = 0; ext_interrupt = 0;
    mem_pc = '0; jump_target = '0;
  endtask

  task automatic check_reset_values();
    check("rst_instruction", 32'(instruction), 32'(NOP));
    check("rst_if_id_pc", if_id_pc, 32'd0);
    check("rst_if_id_imm", 32'(if_id_imm), 32'd0);
    check("rst_interrupt_signal", 32'(interrupt_signal), 32'd0);
    check("rst_return_pc", return_pc, 32'd0);
    check("rst_fetch_ready", 32'(fetch_ready), 32'd0);
    check("rst_imem_addr", imem_addr, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 16'($urandom);
    mem[0] = 16'h0000; mem[1] = 16'h0010; mem[16'h10] = 16'h1960;
    mem[2] = 16'h0000; mem[3] = 16'h0200;
    mem[16'h20] = 16'h5555; mem[16'h21] = 16'h00AB;
    idle();
    reset = 0;
    model_reset();
    @(posedge clk); #1;
    check_reset_values();
    reset = 1;

    // boot: vector halves then first fetch
    cycle(); cycle(); cycle();
    check("boot_instruction", 32'(instruction), 32'h1960);
    check("boot_if_id_pc", if_id_pc, 32'h10);

    // LDM: opcode at 0x20, immediate word at 0x21
    jump_taken = 1; jump_target = 32'h20; cycle(); idle();
    cycle();
    clear_instruction = 1; cycle(); idle();
    check("ldm_imm", 32'(if_id_imm), 32'h00AB);
    check("ldm_instr", 32'(instruction), 32'(NOP));
    #1 check("ldm_pc", imem_addr, 32'h22);

    // stall holds, jump overrides stall
    hazard_stall = 1; cycle(); cycle(); cycle();
    jump_taken = 1; jump_target = 32'h100; cycle(); idle();
    check("jump_instr", 32'(instruction), 32'(NOP));
    #1 check("jump_pc", imem_addr, 32'h100);

    // interrupt held off by a stall, then a single pulse
    stall_fetch_from_cu = 1; ext_interrupt = 1; cycle();
    ext_interrupt = 0; cycle(); cycle(); cycle();
    check("int_held", 32'(interrupt_signal), 32'd0);
    idle(); cycle();
    check("int_pulse", 32'(interrupt_signal), 32'd1);
    cycle();
    check("int_single", 32'(interrupt_signal), 32'd0);

    // interrupt vector load from PC 0x33
    jump_taken = 1; jump_target = 32'h33; cycle(); idle();
    pc_choose_interrupt = 1; cycle(); idle();
    check("ivec_return_pc", return_pc, 32'h33);
    cycle(); cycle();
    #1 check("ivec_pc", imem_addr, 32'h200);

    // memory return beats jump
    pc_choose_memory = 1; mem_pc = 32'h44; jump_taken = 1; jump_target = 32'h99;
    cycle(); idle();
    #1 check("ret_pc", imem_addr, 32'h44);

    // reset during IVEC_LO
    pc_choose_interrupt = 1; cycle(); idle(); cycle();
    reset = 0; #1;
    model_reset();
    check_reset_values();
    @(posedge clk); #1;
    reset = 1;
    cycle(); cycle(); cycle();
    check("reboot_instruction", 32'(instruction), 32'h1960);

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      stall_fetch_from_cu = ($urandom_range(0, 5) == 0);
      hazard_stall        = ($urandom_range(0, 5) == 0);
      clear_instruction   = ($urandom_range(0, 7) == 0);
      pc_write_cu         = ($urandom_range(0, 7) != 0);
      pc_choose_memory    = ($urandom_range(0, 15) == 0);
      jump_taken          = ($urandom_range(0, 9) == 0);
      pc_choose_interrupt = ($urandom_range(0, 31) == 0);
      ext_interrupt       = ($urandom_range(0, 3) == 0);
      mem_pc              = $urandom;
      jump_target         = (n % 3 == 0) ? 32'hFFFF_FFFE : $urandom;
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage pipelined RISC core; sits directly upstream of the decode control unit and feeds it.
- Owns the PC register and the IF/ID pipeline register (instruction, PC, immediate word).
- Loads the reset vector and the interrupt vector from instruction memory, selects the next PC, and latches external interrupts.
- Honours the decode unit's stall, clear and PC-write controls.

Parameters:
- PC_W, 32, PC / instruction-memory word-address width.
- INSTR_W, 16, instruction word width.
- RESET_VEC_ADDR, 0, address of reset-vector high half; low half at +1.
- INT_VEC_ADDR, 2, address of interrupt-vector high half; low half at +1.
- NOP_INSTR, 16'h4000, bubble encoding.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low
- imem_addr  out  PC_W  instruction-memory word address (combinational from state/PC)
- imem_data  in  INSTR_W  instruction-memory read data, same-cycle (combinational memory)
- stall_fetch_from_cu  in  1  decode-unit stall: hold PC and IF/ID
- hazard_stall  in  1  hazard-unit stall: same effect as stall_fetch_from_cu
- clear_instruction  in  1  current fetched word is LDM immediate / discard
- pc_write_cu  in  1  PC write enable from decode unit
- pc_choose_memory  in  1  load PC from mem_pc (RET/RTI)
- mem_pc  in  PC_W  PC value popped by memory stage
- jump_taken  in  1  execute-stage taken branch/jump/call
- jump_target  in  PC_W  branch target
- pc_choose_interrupt  in  1  start interrupt-vector load
- ext_interrupt  in  1  external interrupt request, single-cycle pulse or level
- instruction  out  INSTR_W  IF/ID instruction
- if_id_pc  out  PC_W  IF/ID PC (address of instruction)
- if_id_imm  out  INSTR_W  captured immediate word
- interrupt_signal  out  1  one-cycle interrupt request to decode unit
- return_pc  out  PC_W  PC to push on interrupt, frozen at dispatch
- fetch_ready  out  1  high in RUN state

Behaviour:
- States: BOOT_HI, BOOT_LO, RUN, IVEC_HI, IVEC_LO.
- Reset (async, while reset=0):
  - state=BOOT_HI, PC=0, instruction=NOP_INSTR, if_id_pc=0, if_id_imm=0.
  - int_pending=0, interrupt_signal=0, return_pc=0, fetch_ready=0.
  - Reset asserted mid-operation aborts any vector load; on release the stage restarts at BOOT_HI.
- BOOT_HI: imem_addr=RESET_VEC_ADDR; PC[31:16]<=imem_data; ->BOOT_LO.
- BOOT_LO: imem_addr=RESET_VEC_ADDR+1; PC[15:0]<=imem_data; ->RUN. The first real fetch is in cycle 3 after reset release.
- IVEC_HI / IVEC_LO: same as BOOT_HI / BOOT_LO using INT_VEC_ADDR; IVEC_LO ->RUN.
- In IVEC_HI, IVEC_LO, BOOT_HI and BOOT_LO, IF/ID holds NOP_INSTR.
- RUN: imem_addr=PC. Per-cycle priority, highest first:
  1. pc_choose_interrupt: return_pc<=PC; IF/ID<=NOP; ->IVEC_HI.
  2. pc_choose_memory: PC<=mem_pc; IF/ID<=NOP. Overrides stalls and pc_write_cu.
  3. jump_taken: PC<=jump_target; IF/ID<=NOP. Overrides stalls and pc_write_cu.
  4. stall_fetch_from_cu | hazard_stall | !pc_write_cu: PC and IF/ID hold.
  5. clear_instruction: if_id_imm<=imem_data; instruction<=NOP; if_id_pc<=PC; PC<=PC+1.
  6. Normal: instruction<=imem_data; if_id_pc<=PC; PC<=PC+1.
- PC arithmetic is modulo 2^PC_W; 32'hFFFF_FFFF+1 wraps to 0.
- Interrupt handling:
  - ext_interrupt rising edge (registered previous value) sets int_pending.
  - interrupt_signal pulses for exactly one cycle when int_pending=1, state=RUN, and no stall, clear_instruction or redirect is active that cycle. int_pending clears in the same cycle.
  - A new edge arriving while pending is merged; no queueing.
  - A new edge in the same cycle the pulse is issued sets int_pending again.
- fetch_ready = (state==RUN).

Decomposition:
- Shared package cpu_pkg: fetch_state_t enum (BOOT_HI, BOOT_LO, RUN, IVEC_HI, IVEC_LO), NOP_INSTR, RESET_VEC_ADDR, INT_VEC_ADDR. Decode unit reuses NOP_INSTR.
- One sub-module: if_id_reg, the IF/ID pipeline register with hold/flush/load controls.
- PC mux and FSM stay in fetch_stage.

Test Plan:
- Boot: mem[0]=16'h0000, mem[1]=16'h0010, mem[0x10]=16'h1960 → imem_addr 0,1,0x10 on cycles 1-3; cycle 4: instruction=16'h1960, if_id_pc=0x10.
- LDM: fetch LDM at 0x20 with clear_instruction=1 on the next word 16'h00AB → if_id_imm=0x00AB, instruction=NOP, PC=0x22.
- Stall vs jump: hazard_stall=1 for 3 cycles → PC and IF/ID constant. With hazard_stall=1 and jump_taken=1, target 0x100 → PC=0x100, instruction=NOP next cycle.
- Interrupt: ext_interrupt pulse while stall_fetch_from_cu=1 → no interrupt_signal until the stall drops, then a single 1-cycle pulse. pc_choose_interrupt at PC=0x33 with mem[2]=0, mem[3]=0x200 → return_pc=0x33, PC=0x200 after 2 cycles.
- RET: pc_choose_memory=1, mem_pc=0x44, and jump_taken=1 in the same cycle → PC=0x44 (memory wins).
- Reset mid-IVEC_LO → outputs return to reset values immediately; boot sequence re-runs from address 0 after release.
